hilo_muldiv_ctrl: RTL and testbench

Sequencer for the HI/LO register pair. It accepts one multiply, divide, accumulate or move-to operation at a time and computes the full 64-bit result. MADD/MSUB use a 64-bit add with carry between LO and HI. It issues exactly one plain write command per operation to the HI/LO register file and stalls MFHI/MFLO readers while an operation is in flight. It sits between the EX stage and the HI/LO register file and never drives the file's Madd/Msub inputs.

---
 rtl/hilo_muldiv_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: one write command per MULT/DIV/MADD/MSUB/MTHI/MTLO.
// Optional macro HILO_FWD_EN: drop Stall during WRITE so readers forward the write data.
module hilo_muldiv_ctrl #(
  parameter int          MUL_LATENCY = 2,
  parameter logic [31:0] DIV_ZERO_LO = 32'hFFFFFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] CurHi,
  input  logic [31:0] CurLo,
  input  logic        ReadReq,
  output logic [31:0] WriteHiData,
  output logic [31:0] WriteLoData,
  output logic        WriteEn,
  output logic        Busy,
  output logic        Done,
  output logic        Stall
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_DIV   = 3'd2,
    S_FIX   = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } acc_t;

  localparam logic [4:0] MUL_CNT_INIT = 5'(MUL_LATENCY - 1);

  function automatic logic [31:0] abs32(input logic [31:0] v);
    abs32 = v[31] ? (32'd0 - v) : v;
  endfunction

  state_t      state_q, state_d;
  acc_t        acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        sgn_q, sgn_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;

  logic [63:0] ext_a_s, ext_b_s, prod_s, cur_s;
  logic [32:0] r33_s, diff_s;

  // Sign- or zero-extending to 64 bits makes one 64-bit multiply serve both signednesses.
  assign ext_a_s = {(sgn_q ? {32{opa_q[31]}} : 32'd0), opa_q};
  assign ext_b_s = {(sgn_q ? {32{opb_q[31]}} : 32'd0), opb_q};
  assign prod_s  = ext_a_s * ext_b_s;
  assign cur_s   = {CurHi, CurLo};

  // Restoring step: quo_q holds the dividend bits still to be shifted in.
  assign r33_s  = {rem_q, quo_q[31]};
  assign diff_s = r33_s - {1'b0, opb_q};

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          case (Op)
            3'd0, 3'd1, 3'd4, 3'd5: begin
              state_d = S_MUL;
              cnt_d   = MUL_CNT_INIT;
              opa_d   = A;
              opb_d   = B;
              sgn_d   = (Op != 3'd1);
              if (Op == 3'd4) begin
                acc_d = ACC_ADD;
              end else if (Op == 3'd5) begin
                acc_d = ACC_SUB;
              end else begin
                acc_d = ACC_NONE;
              end
            end
            3'd2, 3'd3: begin
              if (B == 32'd0) begin
                state_d = S_WRITE;
                hi_d    = A;
                lo_d    = DIV_ZERO_LO;
              end else begin
                state_d = S_DIV;
                cnt_d   = 5'd31;
                rem_d   = 32'd0;
                if (Op == 3'd2) begin
                  quo_d  = abs32(A);
                  opb_d  = abs32(B);
                  qneg_d = A[31] ^ B[31];
                  rneg_d = A[31];
                end else begin
                  quo_d  = A;
                  opb_d  = B;
                  qneg_d = 1'b0;
                  rneg_d = 1'b0;
                end
              end
            end
            3'd6: begin
              state_d = S_WRITE;
              hi_d    = A;
              lo_d    = CurLo;
            end
            3'd7: begin
              state_d = S_WRITE;
              hi_d    = CurHi;
              lo_d    = A;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (cnt_q == 5'd0) begin
          state_d = S_WRITE;
          case (acc_q)
            ACC_ADD: {hi_d, lo_d} = cur_s + prod_s;
            ACC_SUB: {hi_d, lo_d} = cur_s - prod_s;
            default: {hi_d, lo_d} = prod_s;
          endcase
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_DIV: begin
        if (!diff_s[32]) begin
          rem_d = diff_s[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = r33_s[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        if (cnt_q == 5'd0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_FIX: begin
        state_d = S_WRITE;
        hi_d    = rneg_q ? (32'd0 - rem_q) : rem_q;
        lo_d    = qneg_q ? (32'd0 - quo_q) : quo_q;
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    we_d   = (state_d == S_WRITE);
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      acc_q   <= ACC_NONE;
      cnt_q   <= 5'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
    end
  end

  assign WriteHiData = hi_q;
  assign WriteLoData = lo_q;
  assign WriteEn     = we_q;
  assign Done        = we_q;
  assign Busy        = busy_q;

`ifdef HILO_FWD_EN
  assign Stall = ReadReq && busy_q && !we_q;
`else
  assign Stall = ReadReq && busy_q;
`endif

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: latency, results, reset abort, ignored Start, Stall.
module tb_hilo_muldiv_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, Start, ReadReq;
  logic [2:0]  Op;
  logic [31:0] A, B, CurHi, CurLo;
  logic [31:0] WriteHiData, WriteLoData;
  logic        WriteEn, Busy, Done, Stall;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc;
  logic [31:0] hi, lo;

  hilo_muldiv_ctrl #(.MUL_LATENCY(2), .DIV_ZERO_LO(32'hFFFFFFFF)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .CurHi(CurHi), .CurLo(CurLo), .ReadReq(ReadReq),
    .WriteHiData(WriteHiData), .WriteLoData(WriteLoData),
    .WriteEn(WriteEn), .Busy(Busy), .Done(Done), .Stall(Stall)
  );

  always #5 Clk = ~Clk;

  // Drive a request during cycle 0 (inputs change on the falling edge).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
  endtask

  // Wait (bounded) for the write strobe; cyc = -1 when it never comes.
  task automatic wait_write();
    cyc = -1; hi = 32'd0; lo = 32'd0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge Clk);
      if (c == 1) Start = 1'b0;
      if (WriteEn === 1'b1) begin
        cyc = c; hi = WriteHiData; lo = WriteLoData;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; Op = 3'd7; A = 32'h55; B = 32'd0; ReadReq = 1'b1;
    CurHi = 32'd0; CurLo = 32'd0;
    repeat (3) @(negedge Clk);
    n_cmp++; if (WriteHiData !== 32'd0) begin n_err++; $display("FAIL reset_hi got %h want 0", WriteHiData); end
    n_cmp++; if (WriteLoData !== 32'd0) begin n_err++; $display("FAIL reset_lo got %h want 0", WriteLoData); end
    n_cmp++; if ({WriteEn, Done, Busy, Stall} !== 4'b0000) begin n_err++; $display("FAIL reset_ctl got %b want 0000", {WriteEn, Done, Busy, Stall}); end
    Reset = 1'b0; Start = 1'b0; ReadReq = 1'b0;
  endtask

  task automatic test_mul();
    issue(3'd0, 32'hFFFFFFFD, 32'd5);
    wait_write();
    n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL mult_cycle got %0d want 3", cyc); end
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin n_err++; $display("FAIL mult_res got %h_%h want ffffffff_fffffff1", hi, lo); end
    n_cmp++; if (Done !== 1'b1) begin n_err++; $display("FAIL mult_done got %b want 1", Done); end
    issue(3'd1, 32'hFFFFFFFF, 32'd2);
    wait_write();
    n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL multu_cycle got %0d want 3", cyc); end
    n_cmp++; if ({hi, lo} !== 64'h00000001_FFFFFFFE) begin n_err++; $display("FAIL multu_res got %h_%h want 00000001_fffffffe", hi, lo); end
    @(negedge Clk);
    n_cmp++; if ({WriteEn, Busy, WriteLoData} !== {2'b00, 32'hFFFFFFFE}) begin n_err++; $display("FAIL multu_hold got %b%b %h want 00 fffffffe", WriteEn, Busy, WriteLoData); end
  endtask

  task automatic test_div();
    issue(3'd3, 32'd100, 32'd7);
    wait_write();
    n_cmp++; if (cyc !== 34) begin n_err++; $display("FAIL divu_cycle got %0d want 34", cyc); end
    n_cmp++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_err++; $display("FAIL divu_res got %h_%h want 00000002_0000000e", hi, lo); end
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_write();
    n_cmp++; if (cyc !== 34) begin n_err++; $display("FAIL div_cycle got %0d want 34", cyc); end
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin n_err++; $display("FAIL div_neg got %h_%h want ffffffff_fffffffd", hi, lo); end
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_write();
    n_cmp++; if ({hi, lo} !== 64'h00000000_80000000) begin n_err++; $display("FAIL div_ovf got %h_%h want 00000000_80000000", hi, lo); end
    issue(3'd2, 32'd9, 32'hFFFFFFFE);
    wait_write();
    n_cmp++; if ({hi, lo} !== 64'h00000001_FFFFFFFC) begin n_err++; $display("FAIL div_negdivisor got %h_%h want 00000001_fffffffc", hi, lo); end
  endtask

  task automatic test_madd_msub();
    CurHi = 32'd0; CurLo = 32'hFFFFFFFF;
    issue(3'd4, 32'd1, 32'd1);
    wait_write();
    n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL madd_cycle got %0d want 3", cyc); end
    n_cmp++; if ({hi, lo} !== 64'h00000001_00000000) begin n_err++; $display("FAIL madd_res got %h_%h want 00000001_00000000", hi, lo); end
    CurHi = 32'd0; CurLo = 32'd0;
    issue(3'd5, 32'd1, 32'd1);
    wait_write();
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFF) begin n_err++; $display("FAIL msub_res got %h_%h want ffffffff_ffffffff", hi, lo); end
    CurHi = 32'd0; CurLo = 32'd10;
    issue(3'd4, 32'hFFFFFFFE, 32'd3);
    wait_write();
    n_cmp++; if ({hi, lo} !== 64'h00000000_00000004) begin n_err++; $display("FAIL madd_signed got %h_%h want 00000000_00000004", hi, lo); end
  endtask

  task automatic test_move_divzero();
    issue(3'd2, 32'h1234, 32'd0);
    wait_write();
    n_cmp++; if (cyc !== 1) begin n_err++; $display("FAIL divzero_cycle got %0d want 1", cyc); end
    n_cmp++; if ({hi, lo} !== 64'h00001234_FFFFFFFF) begin n_err++; $display("FAIL divzero_res got %h_%h want 00001234_ffffffff", hi, lo); end
    CurHi = 32'd5; CurLo = 32'h77;
    issue(3'd7, 32'hABCD, 32'd0);
    wait_write();
    n_cmp++; if (cyc !== 1) begin n_err++; $display("FAIL mtlo_cycle got %0d want 1", cyc); end
    n_cmp++; if ({hi, lo} !== 64'h00000005_0000ABCD) begin n_err++; $display("FAIL mtlo_res got %h_%h want 00000005_0000abcd", hi, lo); end
    issue(3'd6, 32'hCAFE, 32'd0);
    wait_write();
    n_cmp++; if ({hi, lo} !== 64'h0000CAFE_00000077) begin n_err++; $display("FAIL mthi_res got %h_%h want 0000cafe_00000077", hi, lo); end
  endtask

  task automatic test_reset_mid_div();
    int pulses;
    issue(3'd3, 32'd100, 32'd7);
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      if (c == 1) Start = 1'b0;
    end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    n_cmp++; if ({Busy, WriteEn} !== 2'b00) begin n_err++; $display("FAIL abort_ctl got %b want 00", {Busy, WriteEn}); end
    n_cmp++; if ({WriteHiData, WriteLoData} !== 64'd0) begin n_err++; $display("FAIL abort_data got %h_%h want 0", WriteHiData, WriteLoData); end
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (WriteEn === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL abort_nowrite got %0d pulses want 0", pulses); end
  endtask

  task automatic test_back_to_back();
    int pulses, wcyc, stall_bad;
    logic exp_stall34;
`ifdef HILO_FWD_EN
    exp_stall34 = 1'b0;
`else
    exp_stall34 = 1'b1;
`endif
    ReadReq = 1'b1;
    issue(3'd3, 32'd100, 32'd7);
    pulses = 0; wcyc = -1; stall_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      Start = (c <= 33);
      Op = 3'd7; A = 32'hDEAD;
      if (WriteEn === 1'b1) begin
        pulses++; wcyc = c; hi = WriteHiData; lo = WriteLoData;
      end
      if (c <= 33 && Stall !== 1'b1) stall_bad++;
      if (c == 34) begin
        n_cmp++; if (Stall !== exp_stall34) begin n_err++; $display("FAIL stall_write got %b want %b", Stall, exp_stall34); end
      end
      if (c == 35) begin
        n_cmp++; if ({Busy, Stall} !== 2'b00) begin n_err++; $display("FAIL stall_idle got %b want 00", {Busy, Stall}); end
      end
    end
    Start = 1'b0; ReadReq = 1'b0;
    n_cmp++; if (stall_bad !== 0) begin n_err++; $display("FAIL stall_busy got %0d low cycles want 0", stall_bad); end
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL ignore_start got %0d pulses want 1", pulses); end
    n_cmp++; if (wcyc !== 34) begin n_err++; $display("FAIL ignore_cycle got %0d want 34", wcyc); end
    n_cmp++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_err++; $display("FAIL ignore_res got %h_%h want 00000002_0000000e", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_madd_msub();
    test_move_divzero();
    test_reset_mid_div();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
